// File: rtl/codec_pkg.sv
// rtl/codec_pkg.sv - shared WM8731 codec definitions: states, addresses, configuration ROM
package codec_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PWRUP,
        ST_REQ,
        ST_WAIT,
        ST_GAP,
        ST_DONE,
        ST_ERROR
    } cfg_state_e;

    localparam logic [6:0] CODEC_DEV_ADDR = 7'h1A;

    localparam logic [6:0] WM_R0_LLINE  = 7'h00;
    localparam logic [6:0] WM_R4_APATH  = 7'h04;
    localparam logic [6:0] WM_R5_DPATH  = 7'h05;
    localparam logic [6:0] WM_R6_POWER  = 7'h06;
    localparam logic [6:0] WM_R7_FORMAT = 7'h07;
    localparam logic [6:0] WM_R8_SAMPLE = 7'h08;
    localparam logic [6:0] WM_R9_ACTIVE = 7'h09;
    localparam logic [6:0] WM_R15_RESET = 7'h0F;

    localparam int CFG_ROM_DEPTH = 8;

    // Order matters: reset first, activate last so the codec only runs fully configured.
    localparam logic [15:0] CFG_ROM [CFG_ROM_DEPTH] = '{
        {WM_R15_RESET, 9'h000},
        {WM_R6_POWER,  9'h079},
        {WM_R4_APATH,  9'h005},
        {WM_R5_DPATH,  9'h000},
        {WM_R7_FORMAT, 9'h041},
        {WM_R8_SAMPLE, 9'h000},
        {WM_R0_LLINE,  9'h017},
        {WM_R9_ACTIVE, 9'h001}
    };

endpackage

// File: rtl/cfg_rom.sv
// rtl/cfg_rom.sv - combinational step-to-word lookup into the codec configuration ROM
module cfg_rom
    import codec_pkg::*;
#(
    parameter int SW = 4
) (
    input  logic [SW-1:0] i_step,
    output logic [15:0]   o_word
);

    // Steps past the end of the table read as zero (DONE parks the step there).
    always_comb begin
        o_word = 16'h0000;
        for (int i = 0; i < CFG_ROM_DEPTH; i++) begin
            if (i_step == SW'(i)) begin
                o_word = CFG_ROM[i];
            end
        end
    end

endmodule

// File: rtl/codec_cfg_seq.sv
// rtl/codec_cfg_seq.sv - WM8731 power-up configuration sequencer driving an I2C master handshake
module codec_cfg_seq
    import codec_pkg::*;
#(
    parameter int         NUM_WRITES   = 8,
    parameter int         PWRUP_CYCLES = 1000,
    parameter int         GAP_CYCLES   = 64,
    parameter int         RETRY_MAX    = 3,
    parameter logic [6:0] DEV_ADDR     = CODEC_DEV_ADDR,
    localparam int        SW           = $clog2(NUM_WRITES + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    output logic          o_i2c_req,
    output logic [6:0]    o_i2c_dev,
    output logic [15:0]   o_i2c_word,
    input  logic          i_i2c_ready,
    input  logic          i_i2c_done,
    input  logic          i_i2c_nack,
    output logic          o_busy,
    output logic          o_cfg_done,
    output logic          o_cfg_error,
    output logic          o_mic_enable,
    output logic [SW-1:0] o_cfg_step
);

    localparam int CNT_MAX = (PWRUP_CYCLES > GAP_CYCLES) ? PWRUP_CYCLES : GAP_CYCLES;
    localparam int CW      = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam int RW      = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

    cfg_state_e    r_state;
    cfg_state_e    w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [SW-1:0] r_step;
    logic [SW-1:0] w_step_nxt;
    logic [RW-1:0] r_retry;
    logic [RW-1:0] w_retry_nxt;
    logic          r_last_nack;
    logic          w_last_nack_nxt;

    // Reset lands in PWRUP so configuration starts on its own.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_PWRUP;
            r_cnt       <= '0;
            r_step      <= '0;
            r_retry     <= '0;
            r_last_nack <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_step      <= w_step_nxt;
            r_retry     <= w_retry_nxt;
            r_last_nack <= w_last_nack_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_step_nxt      = r_step;
        w_retry_nxt     = r_retry;
        w_last_nack_nxt = r_last_nack;
        // start wins over everything, including a done in the same cycle.
        if (i_start) begin
            w_state_nxt     = ST_PWRUP;
            w_cnt_nxt       = '0;
            w_step_nxt      = '0;
            w_retry_nxt     = '0;
            w_last_nack_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_PWRUP: begin
                    if (r_cnt == CW'(PWRUP_CYCLES)) begin
                        w_state_nxt = ST_REQ;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                ST_REQ: begin
                    if (i_i2c_ready) begin
                        w_state_nxt = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (i_i2c_done) begin
                        w_state_nxt     = ST_GAP;
                        w_cnt_nxt       = '0;
                        w_last_nack_nxt = i_i2c_nack;
                    end
                end
                ST_GAP: begin
                    if (r_cnt == CW'(GAP_CYCLES)) begin
                        w_cnt_nxt = '0;
                        if (!r_last_nack) begin
                            w_step_nxt  = r_step + 1'b1;
                            w_retry_nxt = '0;
                            w_state_nxt = (r_step == SW'(NUM_WRITES - 1)) ? ST_DONE : ST_REQ;
                        end else if (r_retry == RW'(RETRY_MAX)) begin
                            w_state_nxt = ST_ERROR;
                        end else begin
                            w_retry_nxt = r_retry + 1'b1;
                            w_state_nxt = ST_REQ;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = r_state;
                end
            endcase
        end
    end

    cfg_rom #(
        .SW(SW)
    ) u_cfg_rom (
        .i_step(r_step),
        .o_word(o_i2c_word)
    );

    // Status outputs decode the state register only, so reset drops them immediately.
    assign o_i2c_req    = (r_state == ST_REQ);
    assign o_i2c_dev    = DEV_ADDR;
    assign o_busy       = !((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERROR));
    assign o_cfg_done   = (r_state == ST_DONE);
    assign o_cfg_error  = (r_state == ST_ERROR);
    assign o_mic_enable = (r_state == ST_DONE);
    assign o_cfg_step   = r_step;

endmodule

// File: tb/tb_codec_cfg_seq.sv
// tb/tb_codec_cfg_seq.sv - self-checking bench for codec_cfg_seq with a transaction-level codec model
module tb_codec_cfg_seq;

    localparam int P  = 40;
    localparam int G  = 6;
    localparam int RM = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    logic        i_rst_n, i_start, i_i2c_ready, i_i2c_done, i_i2c_nack;
    logic        o_i2c_req, o_busy, o_cfg_done, o_cfg_error, o_mic_enable;
    logic [6:0]  o_i2c_dev;
    logic [15:0] o_i2c_word;
    logic [3:0]  o_cfg_step;

    logic        z_rst_n, z_start, z_ready, z_done, z_nack;
    logic        z_req, z_busy, z_cfg_done, z_err, z_mic;
    logic [6:0]  z_dev;
    logic [15:0] z_word;
    logic [3:0]  z_step;
    bit          z_finished = 0;

    logic [15:0] GOLD [8] = '{16'h1E00, 16'h0C79, 16'h0805, 16'h0A00,
                              16'h0E41, 16'h1000, 16'h0017, 16'h1201};

    int n_pass = 0;
    int n_total = 0;
    int m_step, m_att;
    bit m_err;

    codec_cfg_seq #(.NUM_WRITES(8), .PWRUP_CYCLES(P), .GAP_CYCLES(G), .RETRY_MAX(RM)) u_dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_start(i_start),
        .o_i2c_req(o_i2c_req), .o_i2c_dev(o_i2c_dev), .o_i2c_word(o_i2c_word),
        .i_i2c_ready(i_i2c_ready), .i_i2c_done(i_i2c_done), .i_i2c_nack(i_i2c_nack),
        .o_busy(o_busy), .o_cfg_done(o_cfg_done), .o_cfg_error(o_cfg_error),
        .o_mic_enable(o_mic_enable), .o_cfg_step(o_cfg_step)
    );

    codec_cfg_seq #(.NUM_WRITES(8), .PWRUP_CYCLES(0), .GAP_CYCLES(0), .RETRY_MAX(RM)) u_dut_zero (
        .i_clk(clk), .i_rst_n(z_rst_n), .i_start(z_start),
        .o_i2c_req(z_req), .o_i2c_dev(z_dev), .o_i2c_word(z_word),
        .i_i2c_ready(z_ready), .i_i2c_done(z_done), .i_i2c_nack(z_nack),
        .o_busy(z_busy), .o_cfg_done(z_cfg_done), .o_cfg_error(z_err),
        .o_mic_enable(z_mic), .o_cfg_step(z_step)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Behaves as the I2C master; the model tracks which ROM step/attempt the codec should see.
    task automatic run_cfg(input logic [31:0] plan, input int rdy_dly, input bit rnd,
                           input int abort_step, input int rel_edge, output int n_req);
        int wait_n, pend, done_edge;
        bit in_req, first, ended;
        logic [15:0] held;
        m_step = 0; m_att = 0; m_err = 0;
        n_req = 0; pend = 0; in_req = 0; first = 1; ended = 0;
        done_edge = 0; wait_n = 0; held = '0;
        for (int t = 0; t < 5000; t++) begin
            @(negedge clk);
            i_start = 0; i_i2c_ready = 0; i_i2c_done = 0;
            i_i2c_nack = rnd ? 1'($urandom) : 1'b0;
            if (o_cfg_done || o_cfg_error) begin
                ended = 1;
                break;
            end
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    i_i2c_done = 1;
                    i_i2c_nack = (m_step < 8) ? plan[m_step*4 + m_att] : 1'b0;
                    done_edge = edge_n + 1;
                    if (m_step == abort_step) begin
                        i_start = 1;
                        return;
                    end
                    if (i_i2c_nack) begin
                        m_att++;
                        if (m_att > RM) m_err = 1;
                    end else begin
                        m_step++;
                        m_att = 0;
                    end
                end
            end else if (o_i2c_req) begin
                if (!in_req) begin
                    check(first ? "pwrup_to_req" : "done_to_req",
                          edge_n - (first ? rel_edge : done_edge), first ? P + 1 : G + 1);
                    first = 0; in_req = 1; wait_n = 0; held = o_i2c_word;
                end else begin
                    check("word_stable", o_i2c_word, held);
                end
                if (wait_n >= rdy_dly) begin
                    i_i2c_ready = 1;
                    check("word_vs_model", o_i2c_word, (m_step < 8) ? GOLD[m_step] : 16'hDEAD);
                    n_req++;
                    in_req = 0;
                    pend = rnd ? 1 + int'($urandom_range(0, 3)) : 2;
                end else begin
                    wait_n++;
                end
            end else if (rnd && $urandom_range(0, 7) == 0) begin
                i_i2c_done = 1;
            end
        end
        if (!ended) check("sequence_timeout", 0, 1);
        else check("done_to_terminal", edge_n - done_edge, G + 1);
    endtask

    task automatic pulse_start(output int rel_edge);
        @(negedge clk);
        i_start = 1; i_i2c_ready = 0; i_i2c_done = 0; i_i2c_nack = 0;
        rel_edge = edge_n + 1;
    endtask

    task automatic check_end(input bit exp_err, input int exp_step);
        check("end_error", o_cfg_error, exp_err);
        check("end_done", o_cfg_done, !exp_err);
        check("end_mic", o_mic_enable, !exp_err);
        check("end_busy", o_busy, 0);
        check("end_step", o_cfg_step, exp_step);
    endtask

    typedef struct {
        logic [31:0] plan;
        int          rdy_dly;
        int          exp_req;
        bit          exp_err;
        int          exp_step;
    } vec_t;

    initial begin : zero_delay_run
        int z_rel, z_done_edge, z_req_n;
        z_rst_n = 0; z_start = 0; z_ready = 1; z_done = 0; z_nack = 0;
        repeat (3) @(negedge clk);
        z_rst_n = 1; z_rel = edge_n; z_done_edge = 0; z_req_n = 0;
        for (int t = 0; t < 200 && !z_cfg_done; t++) begin
            @(negedge clk);
            z_done = 0;
            if (z_req) begin
                check("zero_req_latency", edge_n - ((z_req_n == 0) ? z_rel : z_done_edge), 1);
                check("zero_word", z_word, GOLD[z_req_n & 7]);
                z_req_n++;
                @(negedge clk);
                z_done = 1;
                z_done_edge = edge_n + 1;
            end
        end
        check("zero_cfg_done", z_cfg_done, 1);
        check("zero_mic_latency", edge_n - z_done_edge, 1);
        check("zero_req_count", z_req_n, 8);
        check("zero_step", z_step, 8);
        z_finished = 1;
    end

    initial begin : main
        vec_t vecs [6];
        int rel, nreq, dummy;
        vecs[0] = '{32'h0000_0000, 0,  8, 1'b0, 8};
        vecs[1] = '{32'h0003_0000, 1, 10, 1'b0, 8};
        vecs[2] = '{32'h0000_0F00, 0,  6, 1'b1, 2};
        vecs[3] = '{32'h0000_0000, 20, 8, 1'b0, 8};
        vecs[4] = '{32'hF000_0000, 2, 11, 1'b1, 7};
        vecs[5] = '{32'h0000_0007, 0, 11, 1'b0, 8};

        i_rst_n = 0; i_start = 0; i_i2c_ready = 0; i_i2c_done = 0; i_i2c_nack = 0;
        repeat (3) @(negedge clk);
        check("rst_req", o_i2c_req, 0);
        check("rst_word", o_i2c_word, 16'h1E00);
        check("rst_busy", o_busy, 1);
        check("rst_done", o_cfg_done, 0);
        check("rst_error", o_cfg_error, 0);
        check("rst_mic", o_mic_enable, 0);
        check("rst_step", o_cfg_step, 0);
        check("dev_addr", o_i2c_dev, 7'h1A);
        i_rst_n = 1;
        rel = edge_n;

        for (int i = 0; i < 6; i++) begin
            if (i > 0) pulse_start(rel);
            run_cfg(vecs[i].plan, vecs[i].rdy_dly, 1'b0, -1, rel, nreq);
            check("vec_requests", nreq, vecs[i].exp_req);
            check_end(vecs[i].exp_err, vecs[i].exp_step);
        end

        // start coincident with the step-5 done, then a stale done while powering up
        pulse_start(rel);
        run_cfg(32'h0, 0, 1'b0, 5, rel, dummy);
        rel = edge_n + 1;
        @(negedge clk);
        i_start = 0; i_i2c_done = 1; i_i2c_nack = 0;
        check("abort_step", o_cfg_step, 0);
        check("abort_busy", o_busy, 1);
        check("abort_mic", o_mic_enable, 0);
        check("abort_req", o_i2c_req, 0);
        run_cfg(32'h0, 0, 1'b0, -1, rel, nreq);
        check("abort_rerun_requests", nreq, 8);
        check_end(1'b0, 8);

        for (int k = 0; k < 6; k++) begin
            pulse_start(rel);
            run_cfg($urandom & $urandom & $urandom, int'($urandom_range(0, 3)), 1'b1, -1, rel, nreq);
            check_end(m_err, m_err ? m_step : 8);
        end

        pulse_start(rel);
        run_cfg(32'h0, 0, 1'b0, -1, rel, nreq);
        check("pre_reset_mic", o_mic_enable, 1);
        #2 i_rst_n = 0;
        #1;
        check("async_rst_mic", o_mic_enable, 0);
        check("async_rst_done", o_cfg_done, 0);
        check("async_rst_step", o_cfg_step, 0);
        @(negedge clk);
        i_rst_n = 1;
        rel = edge_n;
        run_cfg(32'h0, 0, 1'b0, -1, rel, nreq);
        check("post_reset_requests", nreq, 8);
        check_end(1'b0, 8);

        for (int i = 0; i < 2000 && !z_finished; i++) @(negedge clk);
        check("zero_run_finished", z_finished, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/codec_cfg_seq.md
# codec_cfg_seq

Configuration sequencer for the WM8731 audio codec, the block that must finish before the serial-audio mic deserialiser produces meaningful samples. After reset it waits a power-up delay, then issues a fixed list of 16-bit register writes (7-bit register address plus 9-bit data) to an external I2C master over a request/done handshake, retrying NACKed writes. When every write succeeds it raises `mic_enable`, which gates the valid strobe of the audio capture path.

## Interface
- `NUM_WRITES`, 8: entries in the configuration ROM; sets the `cfg_step` width as `$clog2(NUM_WRITES+1)`.
- `PWRUP_CYCLES`, 1000: clock cycles to wait after reset release or `start` before the first write.
- `GAP_CYCLES`, 64: idle cycles between a completed write and the next request.
- `RETRY_MAX`, 3: retries per write after a NACK; the block issues at most `RETRY_MAX+1` attempts per write.
- `DEV_ADDR`, 7'h1A: I2C device address of the codec.
- `clk` in 1: system clock; all logic sits on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: restarts the whole sequence from any state; single-cycle pulse.
- `i2c_req` out 1: requests one write; held high until `i2c_ready` is sampled high.
- `i2c_dev` out 7: device address, equal to `DEV_ADDR` at all times.
- `i2c_word` out 16: `{reg_addr[6:0], reg_data[8:0]}` for the current step; stable while `i2c_req` is high.
- `i2c_ready` in 1: the master accepts the request in a cycle where `i2c_req` and `i2c_ready` are both high.
- `i2c_done` in 1: one-cycle pulse marking the end of the accepted transfer.
- `i2c_nack` in 1: sampled only in the `i2c_done` cycle; 1 means the transfer failed.
- `busy` out 1: high in every state except IDLE, DONE and ERROR.
- `cfg_done` out 1: high in DONE.
- `cfg_error` out 1: high in ERROR.
- `mic_enable` out 1: high only in DONE.
- `cfg_step` out `$clog2(NUM_WRITES+1)`: index of the current write; equals `NUM_WRITES` in DONE.

## Operation
- States and transitions:
  - IDLE: leave to PWRUP when `start` is high.
  - PWRUP: wait `PWRUP_CYCLES`, then go to REQ.
  - REQ: on handshake, go to WAIT.
  - WAIT: on `i2c_done`, go to GAP.
  - GAP: wait `GAP_CYCLES`, then go to REQ, DONE or ERROR.
  - DONE and ERROR: terminal until `start`.
- Leaving reset the block enters PWRUP directly, so configuration is automatic after reset.
- Every transition into PWRUP clears `cfg_step`, the retry counter and the wait counter.
- On `i2c_done`, the block latches `i2c_nack` into a `last_nack` flag.
- GAP expiry, three cases:
  - `last_nack`=0: increment `cfg_step` and clear the retry counter. If the new step equals `NUM_WRITES`, go to DONE; otherwise go to REQ.
  - `last_nack`=1 with retry count below `RETRY_MAX`: increment the retry counter, keep `cfg_step` unchanged, go to REQ.
  - `last_nack`=1 with retry count equal to `RETRY_MAX`: go to ERROR, with `cfg_step` frozen at the failing index.
- ROM order:
  - R15 reset 16'h1E00
  - R6 power (mic and ADC on, DAC off) 16'h0C79
  - R4 analogue path (mic input, boost) 16'h0805
  - R5 digital path 16'h0A00
  - R7 format (master, left-justified, 16-bit) 16'h0E41
  - R8 sampling (48 kHz normal) 16'h1000
  - R0 left line-in 16'h0017
  - R9 active 16'h1201
- The ROM is indexed by `cfg_step`.
- `i2c_done` outside WAIT is ignored.
- `start` has priority over every other event, including a `i2c_done` in the same cycle. After a `start` during WAIT the block ignores the stale `i2c_done`, and the master must tolerate an abandoned transfer.

## Timing
- Reset values:
  - `i2c_req`=0
  - `i2c_word`=ROM[0]
  - `busy`=1, because the state is PWRUP
  - `cfg_done`=0
  - `cfg_error`=0
  - `mic_enable`=0
  - `cfg_step`=0
- All outputs are registered or decoded from the state register only; there is no combinational path from inputs to outputs.
- `i2c_req` rises in the first REQ cycle and falls in the cycle after the handshake.
- From reset release to the first `i2c_req` is exactly `PWRUP_CYCLES+1` cycles.
- From the `i2c_done` cycle to the next `i2c_req` is exactly `GAP_CYCLES+1` cycles.
- `mic_enable` rises `GAP_CYCLES+1` cycles after the final successful `i2c_done`.
- Counters saturate at 0 and never wrap. `PWRUP_CYCLES`=0 and `GAP_CYCLES`=0 each give a single-cycle state.

## Structure
- Package `codec_pkg` holds:
  - the `cfg_state_e` enum
  - the `CODEC_DEV_ADDR` constant
  - the WM8731 register-address localparams
  - the `CFG_ROM` constant array of 16-bit words
- The package is shared with the I2C master and the mic capture path.
- One sub-module, `cfg_rom`: a combinational lookup from step to word, kept separate so the ROM contents can change.

## Test plan
- Reset release with `i2c_ready`=1 and an ACK responder: eight writes, with words in ROM order 1E00, 0C79, 0805, 0A00, 0E41, 1000, 0017, 1201. Then `cfg_done`=1, `mic_enable`=1, `cfg_step`=8.
- NACK on step 4 twice, then ACK: 16'h0E41 is issued three times, and the sequence completes with `cfg_error`=0.
- NACK on step 2 every attempt: four requests of 16'h0805, then `cfg_error`=1, `cfg_step`=2, `mic_enable`=0, `busy`=0.
- `i2c_ready` held low for 20 cycles in REQ: `i2c_req` and `i2c_word` stay stable for all 20 cycles, with exactly one handshake.
- `start` pulsed mid-WAIT at step 5, coincident with `i2c_done`: the block returns to PWRUP, `cfg_step`=0, `mic_enable`=0, and after the power-up wait the first word is 16'h1E00 again.
- `rst_n` asserted asynchronously in DONE: `mic_enable` falls in the same cycle with no clock edge, and the full sequence reruns after release.
